// File: rtl/seg_scan_ctrl_if.sv
// Display-value update handshake between a requester and seg_scan_ctrl.
interface seg_scan_ctrl_if;
  logic        upd_req;
  logic [23:0] upd_data;
  logic        upd_ack;

  modport master (output upd_req, output upd_data, input upd_ack);
  modport slave  (input upd_req, input upd_data, output upd_ack);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed display scanner: blank-then-show slots, frame-aligned
// (tear-free) loading of the display value.
module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  seg_scan_ctrl_if.slave      upd,
  output logic [23:0]         disp_num,
  output logic [2:0]          Scanning,
  output logic                blank,
  output logic                frame_done
);

  localparam logic [19:0] CNT_LAST  = 20'(DIV - 1);
  localparam logic [19:0] BLNK_LAST = 20'(BLANK - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t      state, state_nx;
  logic [19:0] cnt, cnt_nx;
  logic [2:0]  scan_nx;
  logic        fd_nx;
  logic        armed;
  logic        boundary, load;

  // A request is fresh only after upd_req has been seen low; reset disarms,
  // so a request held across reset needs a drop and re-raise.
  assign boundary = (state == S_SHOW) && (cnt == CNT_LAST) && (Scanning == 3'd5);
  assign load     = upd.upd_req && armed && ((state == S_IDLE) || boundary);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    scan_nx  = Scanning;
    fd_nx    = 1'b0;
    if (!en) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      scan_nx  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_BLANK;
          cnt_nx   = '0;
        end
        S_BLANK: begin
          cnt_nx = cnt + 20'd1;
          if (cnt == BLNK_LAST) state_nx = S_SHOW;
        end
        S_SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = S_BLANK;
            scan_nx  = (Scanning == 3'd5) ? 3'd0 : Scanning + 3'd1;
            fd_nx    = (Scanning == 3'd5);
          end else begin
            cnt_nx = cnt + 20'd1;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          scan_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      Scanning    <= '0;
      blank       <= 1'b1;
      frame_done  <= 1'b0;
      disp_num    <= '0;
      upd.upd_ack <= 1'b0;
      armed       <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      Scanning    <= scan_nx;
      blank       <= (state_nx != S_SHOW);
      frame_done  <= fd_nx;
      upd.upd_ack <= load;
      if (load) disp_num <= upd.upd_data;
      if (!upd.upd_req) armed <= 1'b1;
      else if (load)    armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at DIV=8, BLANK=2: vector table plus
// hand sequences for idle loads, held requests, en/boundary clash and reset.
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] disp_num;
  logic [2:0]  Scanning;
  logic        blank, frame_done;
  int          tests = 0;
  int          fails = 0;

  seg_scan_ctrl_if upd ();

  seg_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd(upd),
    .disp_num(disp_num), .Scanning(Scanning), .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        en;
    logic        req;
    logic [23:0] data;
    logic [2:0]  scan;
    logic        blk;
    logic        fd;
    logic        ack;
    logic [23:0] disp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, logic e, logic r, logic [23:0] d, logic [2:0] s,
                              logic b, logic f, logic a, logic [23:0] dn);
    vec_t v;
    v.n = n; v.en = e; v.req = r; v.data = d; v.scan = s;
    v.blk = b; v.fd = f; v.ack = a; v.disp = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] s, input logic b,
                         input logic f, input logic a, input logic [23:0] d);
    chk({tag, " scan"},  32'(Scanning),    32'(s));
    chk({tag, " blank"}, 32'(blank),       32'(b));
    chk({tag, " fdone"}, 32'(frame_done),  32'(f));
    chk({tag, " ack"},   32'(upd.upd_ack), 32'(a));
    chk({tag, " disp"},  32'(disp_num),    32'(d));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // k = edges since en rose; slot = (k-1)/8 mod 6, cnt = (k-1) mod 8
    tbl.push_back(mk( 1, 1, 0, 24'h0,      0, 1, 0, 0, 24'h0));
    tbl.push_back(mk( 1, 1, 0, 24'h0,      0, 1, 0, 0, 24'h0));
    tbl.push_back(mk( 1, 1, 0, 24'h0,      0, 0, 0, 0, 24'h0));
    tbl.push_back(mk( 6, 1, 0, 24'h0,      1, 1, 0, 0, 24'h0));
    tbl.push_back(mk( 2, 1, 0, 24'h0,      1, 0, 0, 0, 24'h0));
    tbl.push_back(mk(10, 1, 0, 24'h0,      2, 0, 0, 0, 24'h0));
    tbl.push_back(mk( 1, 1, 1, 24'h123456, 2, 0, 0, 0, 24'h0));
    tbl.push_back(mk(26, 1, 1, 24'h123456, 5, 0, 0, 0, 24'h0));
    tbl.push_back(mk( 1, 1, 1, 24'h123456, 0, 1, 1, 1, 24'h123456));
    tbl.push_back(mk( 1, 1, 1, 24'h123456, 0, 1, 0, 0, 24'h123456));
    tbl.push_back(mk(47, 1, 0, 24'h0,      0, 1, 1, 0, 24'h123456));
    tbl.push_back(mk(10, 1, 0, 24'h0,      1, 0, 0, 0, 24'h123456));
    tbl.push_back(mk(16, 1, 1, 24'h555555, 3, 0, 0, 0, 24'h123456));
    tbl.push_back(mk(26, 1, 0, 24'h0,      0, 0, 0, 0, 24'h123456));
    tbl.push_back(mk(20, 1, 0, 24'h0,      3, 1, 0, 0, 24'h123456));
    tbl.push_back(mk( 3, 1, 0, 24'h0,      3, 0, 0, 0, 24'h123456));
    tbl.push_back(mk( 1, 0, 0, 24'h0,      0, 1, 0, 0, 24'h123456));
    tbl.push_back(mk( 1, 0, 0, 24'h0,      0, 1, 0, 0, 24'h123456));
    tbl.push_back(mk( 1, 1, 0, 24'h0,      0, 1, 0, 0, 24'h123456));
    tbl.push_back(mk( 1, 1, 0, 24'h0,      0, 1, 0, 0, 24'h123456));
    tbl.push_back(mk( 1, 1, 0, 24'h0,      0, 0, 0, 0, 24'h123456));
    tbl.push_back(mk( 5, 1, 0, 24'h0,      0, 0, 0, 0, 24'h123456));
    tbl.push_back(mk( 1, 1, 0, 24'h0,      1, 1, 0, 0, 24'h123456));

    rst_n = 1'b1; en = 1'b0; upd.upd_req = 1'b0; upd.upd_data = '0;
    #2 rst_n = 1'b0;
    #1 chk_all("reset", 0, 1, 0, 0, 24'h0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk_all("idle_en0", 0, 1, 0, 0, 24'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; upd.upd_req = tbl[i].req; upd.upd_data = tbl[i].data;
      step(tbl[i].n);
      chk_all($sformatf("vec%0d", i), tbl[i].scan, tbl[i].blk, tbl[i].fd,
              tbl[i].ack, tbl[i].disp);
    end

    // idle load, held request gives a single ack, re-arm after a drop
    en = 1'b0; upd.upd_req = 1'b0;
    step(1);
    upd.upd_req = 1'b1; upd.upd_data = 24'hABCDEF;
    step(1);
    chk_all("idle_load", 0, 1, 0, 1, 24'hABCDEF);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk($sformatf("held%0d ack", i), 32'(upd.upd_ack), 32'd0);
    end
    upd.upd_req = 1'b0;
    step(1);
    upd.upd_req = 1'b1; upd.upd_data = 24'h111111;
    step(1);
    chk_all("rearm", 0, 1, 0, 1, 24'h111111);
    upd.upd_req = 1'b0;
    step(1);

    // en low on the frame-boundary edge: IDLE wins, no frame_done, load still happens
    en = 1'b1;
    step(48);
    chk_all("pre_bound", 5, 0, 0, 0, 24'h111111);
    en = 1'b0; upd.upd_req = 1'b1; upd.upd_data = 24'h777777;
    step(1);
    chk_all("en_vs_bound", 0, 1, 0, 1, 24'h777777);
    upd.upd_req = 1'b0;
    step(1);

    // asynchronous reset mid-slot 4 with a request pending
    en = 1'b1;
    step(36);
    chk_all("slot4", 4, 0, 0, 0, 24'h777777);
    upd.upd_req = 1'b1; upd.upd_data = 24'h999999;
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 1, 0, 0, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("post_rst%0d ack", i), 32'(upd.upd_ack), 32'd0);
    end
    chk("post_rst disp", 32'(disp_num), 32'h0);
    en = 1'b0; upd.upd_req = 1'b0;
    step(1);
    upd.upd_req = 1'b1;
    step(1);
    chk_all("reassert", 0, 1, 0, 1, 24'h999999);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
